dds_sine_gen: RTL and testbench
===============================

Name: dds_sine_gen

Overview:
Multi-channel direct-digital-synthesis tone generator for the I2S DAC path. It is the parametrised successor of the fixed 256-entry full-wave sine lookup.
- Per channel: a phase accumulator with programmable phase increment and amplitude scaling.
- Output format is selectable: signed or offset-binary.
- A single quarter-wave ROM is time-shared across channels.
- Sits between the control registers and the I2S serialiser. Produces one frame of NUM_CH samples per serialiser request.

Parameters:
PHASE_W, 24, phase accumulator width per channel
LUT_DEPTH, 8, full-wave address bits taken from phase MSBs; the quarter ROM holds 2^(LUT_DEPTH-2)+1 entries
DATA_WIDTH, 16, sample width
NUM_CH, 2, channel count (>=1)

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
en  in  1  block enable; when low, requests are ignored
phase_inc  in  NUM_CH*PHASE_W  per-channel phase step; channel k at bits [k*PHASE_W +: PHASE_W]
amp  in  NUM_CH*9  per-channel gain; 256 = unity; values >256 are clamped to 256
fmt_offset  in  1  0 = two's complement output, 1 = offset binary
phase_clr  in  1  synchronous clear of all phase accumulators
sample_req  in  1  one-cycle frame request from the serialiser
overrun_clr  in  1  clears the overrun flag
busy  out  1  frame computation in progress
sample_valid  out  1  one-cycle pulse; sample_out is new
sample_out  out  NUM_CH*DATA_WIDTH  frame samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
overrun  out  1  sticky: a request arrived while busy

Behaviour:
- Reset (async, arst_n low): phases = 0; busy = 0; sample_valid = 0; sample_out = 0; overrun = 0; FSM = IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a request at edge T when sample_req & en & !busy.
  - RUN issues channels 0..NUM_CH-1 into the pipeline, one per cycle.
  - RUN -> DONE when the last channel leaves the pipeline.
  - DONE -> IDLE after one cycle.
- Pipeline, for channel k of a request accepted at edge T:
  - T+1+k: ROM address registered.
  - T+2+k: ROM data plus sign registered.
  - T+3+k: scaled result written to the working buffer.
- At T+NUM_CH+3: the working buffer is copied to sample_out as one parallel load, and sample_valid = 1 for that single cycle.
- busy is high from T+1 through the sample_valid cycle inclusive.
- Address: a = phase[PHASE_W-1 -: LUT_DEPTH]; quadrant q = a[LUT_DEPTH-1:LUT_DEPTH-2]; i = the remaining LSBs; Q = 2^(LUT_DEPTH-2).
  - q0: +rom[i]
  - q1: +rom[Q-i]
  - q2: -rom[i]
  - q3: -rom[Q-i]
- ROM contents: rom[j] = round((2^(DATA_WIDTH-1)-1)*sin(pi/2*j/Q)). rom[0] = 0; rom[Q] = 2^(DATA_WIDTH-1)-1.
- Scaling: s_scaled = (s * amp_clamped) >>> 8. Arithmetic shift, floor rounding, full-precision product, result fits DATA_WIDTH.
- Format: when fmt_offset = 1, output = s_scaled + 2^(DATA_WIDTH-1) modulo 2^DATA_WIDTH (MSB inverted). fmt_offset is sampled per channel at the scale stage.
- Phase update: each channel samples using its current phase. The accumulator then advances by phase_inc, modulo 2^PHASE_W, at that channel's address-register cycle.
- phase_inc and amp are sampled at each channel's issue cycle.
- phase_clr:
  - Zeroes all phases at the next edge and takes priority over accumulation.
  - If coincident with an accepted request, that frame uses phase 0 for every channel; the increments are applied afterwards.
  - If asserted while busy, it zeroes phases immediately; channels not yet issued use phase 0.
- sample_req while busy: the request is dropped and overrun is set.
- overrun_clr and a new overrun event in the same cycle: overrun stays 1 (set wins).
- en low mid-frame: the current frame completes; only new requests are ignored.
- Reset mid-frame: the frame is aborted and all state returns to reset values.

Decomposition:
- Package dds_pkg: FSM state enum (IDLE, RUN, DONE), AMP_UNITY = 256, AMP_W = 9, and a function computing quarter-ROM depth from LUT_DEPTH.
- Sub-module quarter_sine_rom (parameters LUT_DEPTH, DATA_WIDTH): registered read, entries generated at elaboration from the formula above.

Test Plan:
All scenarios use defaults (PHASE_W=24, LUT_DEPTH=8, DATA_WIDTH=16, NUM_CH=2), amp = 256 unless stated, fmt_offset = 0.
- Quadrant peaks: phase_clr, then phase_inc ch0 = 0x400000. Four requests -> ch0 = 0x0000, 0x7FFF, 0x0000, 0x8001. sample_valid is exactly 5 cycles after each accepted request; busy = 1 for 5 cycles.
- Amplitude and format: ch0 at phase 0x400000 with amp = 128 -> 0x3FFF. At phase 0xC00000 -> 0xC000. amp = 300 -> 0x7FFF (clamped). fmt_offset = 1 with amp = 256 -> 0xFFFF at q1 peak, 0x0001 at q3 peak.
- Channel independence and wrap: ch0 inc = 0x010000, ch1 inc = 0x020000, 256 requests. ch1 completes two periods, ch0 one. Both sequences match the software model bit-exactly. Phase returns to 0 (wraps modulo 2^24).
- Overrun: sample_req held high for 3 cycles -> one frame produced, overrun = 1. overrun_clr together with another busy request -> overrun stays 1. overrun_clr alone -> overrun = 0.
- phase_clr coincident with a request, after arbitrary accumulation -> both channels output 0x0000. The next frame equals rom[phase_inc MSB address].
- Async reset asserted mid-RUN -> busy, sample_valid, sample_out and overrun are 0 immediately. No sample_valid is produced after release.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared FSM type, gain constants and ROM sizing for the DDS tone generator
package dds_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int AMP_UNITY = 256;
  localparam int AMP_W = 9;
  function automatic int rom_depth(input int lut_depth);
    return (1 << (lut_depth - 2)) + 1;
  endfunction
endpackage

// File: rtl/quarter_sine_rom.sv
// quarter_sine_rom: registered-read quarter-wave sine table, filled at elaboration
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int LUT_DEPTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [LUT_DEPTH-2:0]  addr,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int DEPTH = rom_depth(LUT_DEPTH);
  localparam real PEAK = 2.0 ** (DATA_WIDTH - 1) - 1.0;
  logic [DATA_WIDTH-1:0] rom [DEPTH];
  for (genvar j = 0; j < DEPTH; j++) begin : g_rom
    assign rom[j] = DATA_WIDTH'($rtoi(PEAK * $sin(3.141592653589793 * j / (2.0 * (DEPTH - 1))) + 0.5));
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) data <= '0;
    else data <= rom[addr];
endmodule

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: multi-channel DDS sine generator time-sharing one quarter-wave ROM
module dds_sine_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_DEPTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 2
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         en,
  input  logic [NUM_CH*PHASE_W-1:0]    phase_inc,
  input  logic [NUM_CH*AMP_W-1:0]      amp,
  input  logic                         fmt_offset,
  input  logic                         phase_clr,
  input  logic                         sample_req,
  input  logic                         overrun_clr,
  output logic                         busy,
  output logic                         sample_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] sample_out,
  output logic                         overrun
);
  localparam int CW = $clog2(NUM_CH + 2);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int QW = LUT_DEPTH - 1;
  localparam int PW = DATA_WIDTH + AMP_W + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [CHW-1:0] ic, ch1, ch2;
  logic iss, acc, ovf, v1, v2, neg1, neg2;
  logic [LUT_DEPTH-1:0] a;
  logic [QW-1:0] raddr_n, raddr;
  logic [AMP_W-1:0] amp_k, amp_c, amp1, amp2;
  logic [DATA_WIDTH-1:0] rdata, res;
  logic signed [DATA_WIDTH-1:0] s;
  logic signed [PW-1:0] p;
  logic [NUM_CH*DATA_WIDTH-1:0] wbuf;
  quarter_sine_rom #(.LUT_DEPTH(LUT_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_rom (
    .clk(clk), .arst_n(arst_n), .addr(raddr), .data(rdata)
  );
  always_comb begin
    ic = CHW'(cnt);
    iss = state == RUN && cnt < CW'(NUM_CH);
    acc = sample_req && en && !busy && state == IDLE;
    ovf = sample_req && en && (busy || state != IDLE);
    a = phase[ic][PHASE_W-1 -: LUT_DEPTH];
    // odd quadrants read the table mirrored, so index Q is reachable
    raddr_n = a[LUT_DEPTH-2] ? QW'(1 << (LUT_DEPTH - 2)) - {1'b0, a[LUT_DEPTH-3:0]} : {1'b0, a[LUT_DEPTH-3:0]};
    amp_k = amp[ic*AMP_W +: AMP_W];
    amp_c = amp_k > AMP_W'(AMP_UNITY) ? AMP_W'(AMP_UNITY) : amp_k;
    s = neg2 ? -$signed(rdata) : $signed(rdata);
    p = PW'(s) * PW'($signed({1'b0, amp2}));
    res = DATA_WIDTH'(p >>> 8) ^ {fmt_offset, {(DATA_WIDTH-1){1'b0}}};
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      sample_valid <= 1'b0;
      sample_out <= '0;
      overrun <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      ch1 <= '0;
      ch2 <= '0;
      raddr <= '0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      amp1 <= '0;
      amp2 <= '0;
      wbuf <= '0;
      for (int k = 0; k < NUM_CH; k++) phase[k] <= '0;
    end else begin
      state <= state == IDLE ? (acc ? RUN : IDLE) : state == RUN ? (cnt == CW'(NUM_CH + 1) ? DONE : RUN) : IDLE;
      cnt <= state == RUN ? cnt + CW'(1) : '0;
      busy <= state != IDLE;
      sample_valid <= state == DONE;
      if (state == DONE) sample_out <= wbuf;
      overrun <= ovf || (overrun && !overrun_clr);
      v1 <= iss;
      v2 <= v1;
      ch1 <= ic;
      ch2 <= ch1;
      raddr <= raddr_n;
      neg1 <= a[LUT_DEPTH-1];
      neg2 <= neg1;
      amp1 <= amp_c;
      amp2 <= amp1;
      if (v2) wbuf[ch2*DATA_WIDTH +: DATA_WIDTH] <= res;
      for (int k = 0; k < NUM_CH; k++)
        if (phase_clr) phase[k] <= '0;
        else if (iss && ic == CHW'(k)) phase[k] <= phase[k] + phase_inc[k*PHASE_W +: PHASE_W];
    end
endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: randomized self-checking bench against an arithmetic sine reference model
module tb_dds_sine_gen;
  localparam int PW = 24;
  localparam int DW = 16;
  localparam int N = 2;
  logic clk = 0, arst_n = 0, en = 1, fmt_offset = 0, phase_clr = 0, sample_req = 0, overrun_clr = 0;
  logic [N*PW-1:0] phase_inc;
  logic [N*9-1:0] amp;
  logic busy, sample_valid, overrun;
  logic [N*DW-1:0] sample_out;
  logic [PW-1:0] incs [N];
  logic [PW-1:0] mph [N];
  logic [8:0] amps [N];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign phase_inc = {incs[1], incs[0]};
  assign amp = {amps[1], amps[0]};

  dds_sine_gen dut (
    .clk(clk), .arst_n(arst_n), .en(en), .phase_inc(phase_inc), .amp(amp),
    .fmt_offset(fmt_offset), .phase_clr(phase_clr), .sample_req(sample_req),
    .overrun_clr(overrun_clr), .busy(busy), .sample_valid(sample_valid),
    .sample_out(sample_out), .overrun(overrun)
  );

  function automatic logic [DW-1:0] ref_s(input logic [PW-1:0] ph, input int am, input bit fo);
    int a, q, j, r, sv, v;
    logic [DW-1:0] o;
    a = int'(ph >> 16);
    q = a / 64;
    j = (q % 2 == 1) ? 64 - a % 64 : a % 64;
    r = $rtoi(32767.0 * $sin(3.141592653589793 * j / 128.0) + 0.5);
    sv = q >= 2 ? -r : r;
    v = (sv * (am > 256 ? 256 : am)) >>> 8;
    o = v[DW-1:0];
    if (fo) o[DW-1] = ~o[DW-1];
    return o;
  endfunction

  task automatic model(output logic [N*DW-1:0] e);
    for (int k = 0; k < N; k++) begin
      e[k*DW +: DW] = ref_s(mph[k], int'(amps[k]), fmt_offset);
      mph[k] = mph[k] + incs[k];
    end
  endtask

  task automatic pulse_clr;
    @(negedge clk); phase_clr = 1;
    @(negedge clk); phase_clr = 0;
    for (int k = 0; k < N; k++) mph[k] = '0;
  endtask

  task automatic frame(input bit clr, output logic [N*DW-1:0] got, output int lat, output int bc);
    got = 'x; lat = -1; bc = 0;
    @(negedge clk); sample_req = 1; phase_clr = clr;
    @(negedge clk); sample_req = 0; phase_clr = 0;
    if (clr) for (int k = 0; k < N; k++) mph[k] = '0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (busy) bc++;
      if (sample_valid) begin lat = m; got = sample_out; break; end
    end
  endtask

  task automatic wait_valid(input int lim, output int n, output logic [N*DW-1:0] got);
    n = 0; got = 'x;
    for (int m = 1; m <= lim; m++) begin
      @(negedge clk);
      if (sample_valid) begin n++; got = sample_out; end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({busy, sample_valid, overrun, sample_out} !== '0) begin
      errors++; $display("FAIL reset_hold got %h exp 0", {busy, sample_valid, overrun, sample_out});
    end
    @(negedge clk); arst_n = 1;
    @(negedge clk);
    checks++;
    if ({busy, sample_valid, overrun, sample_out} !== '0) begin
      errors++; $display("FAIL reset_release got %h exp 0", {busy, sample_valid, overrun, sample_out});
    end
  endtask

  task automatic test_quadrants;
    logic [N*DW-1:0] got, e;
    logic [DW-1:0] pk [4];
    int lat, bc;
    pk = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};
    incs[0] = 24'h400000; incs[1] = '0; amps = '{256, 256}; fmt_offset = 0;
    pulse_clr;
    for (int n = 0; n < 4; n++) begin
      frame(0, got, lat, bc);
      model(e);
      checks++;
      if (got[DW-1:0] !== pk[n]) begin errors++; $display("FAIL quad_peak%0d got %h exp %h", n, got[DW-1:0], pk[n]); end
      checks++;
      if (got !== e) begin errors++; $display("FAIL quad_model%0d got %h exp %h", n, got, e); end
      checks++;
      if (lat !== 5 || bc !== 5) begin errors++; $display("FAIL quad_timing%0d got lat %0d busy %0d exp 5 5", n, lat, bc); end
    end
  endtask

  task automatic test_amp_fmt;
    logic [N*DW-1:0] got, e;
    int lat, bc;
    int am_t [10];
    bit fo_t [10], cl_t [10];
    logic [DW-1:0] pk [10];
    am_t = '{128, 128, 128, 128, 300, 300, 256, 256, 256, 256};
    fo_t = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    cl_t = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    pk = '{16'h0000, 16'h3FFF, 16'h0000, 16'hC000, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0001};
    incs[0] = 24'h400000; incs[1] = 24'h100000;
    for (int n = 0; n < 10; n++) begin
      amps[0] = 9'(am_t[n]); fmt_offset = fo_t[n];
      if (cl_t[n]) pulse_clr;
      frame(0, got, lat, bc);
      model(e);
      checks++;
      if (got[DW-1:0] !== pk[n]) begin errors++; $display("FAIL ampfmt_peak%0d got %h exp %h", n, got[DW-1:0], pk[n]); end
      checks++;
      if (got !== e) begin errors++; $display("FAIL ampfmt_model%0d got %h exp %h", n, got, e); end
    end
    fmt_offset = 0; amps[0] = 256;
  endtask

  task automatic test_wrap;
    logic [N*DW-1:0] got, e;
    int lat, bc;
    incs[0] = 24'h010000; incs[1] = 24'h020000; amps = '{256, 256};
    pulse_clr;
    for (int n = 0; n < 256; n++) begin
      frame(0, got, lat, bc);
      model(e);
      checks++;
      if (got !== e || lat !== 5) begin errors++; $display("FAIL wrap%0d got %h lat %0d exp %h lat 5", n, got, lat, e); end
    end
    frame(0, got, lat, bc);
    model(e);
    checks++;
    if (got !== '0) begin errors++; $display("FAIL wrap_zero got %h exp 0", got); end
  endtask

  task automatic test_random;
    logic [N*DW-1:0] got, e;
    int lat, bc;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N; k++) begin
        incs[k] = PW'($urandom);
        amps[k] = 9'($urandom_range(0, 511));
      end
      fmt_offset = 1'($urandom_range(0, 1));
      frame(0, got, lat, bc);
      model(e);
      checks++;
      if (got !== e || lat !== 5 || bc !== 5) begin
        errors++; $display("FAIL random%0d got %h lat %0d busy %0d exp %h 5 5", n, got, lat, bc, e);
      end
    end
    fmt_offset = 0; amps = '{256, 256};
  endtask

  task automatic test_enable;
    logic [N*DW-1:0] got, e;
    int n;
    en = 0;
    @(negedge clk); sample_req = 1;
    @(negedge clk); sample_req = 0;
    wait_valid(10, n, got);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL en_low_ignored got %0d frames exp 0", n); end
    en = 1;
    @(negedge clk); sample_req = 1;
    @(negedge clk); sample_req = 0; en = 0;
    wait_valid(10, n, got);
    model(e);
    en = 1;
    checks++;
    if (n !== 1 || got !== e) begin errors++; $display("FAIL en_midframe got %0d %h exp 1 %h", n, got, e); end
  endtask

  task automatic test_overrun;
    logic [N*DW-1:0] got, e;
    int n;
    incs[0] = PW'($urandom); incs[1] = PW'($urandom);
    @(negedge clk); overrun_clr = 1;
    @(negedge clk); overrun_clr = 0; sample_req = 1;
    repeat (3) @(negedge clk);
    sample_req = 0;
    wait_valid(12, n, got);
    model(e);
    checks++;
    if (n !== 1 || got !== e) begin errors++; $display("FAIL ovr_held got %0d %h exp 1 %h", n, got, e); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    @(negedge clk); sample_req = 1;
    @(negedge clk); overrun_clr = 1;
    @(negedge clk); sample_req = 0; overrun_clr = 0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
    wait_valid(10, n, got);
    model(e);
    checks++;
    if (n !== 1 || got !== e) begin errors++; $display("FAIL ovr_frame got %0d %h exp 1 %h", n, got, e); end
    @(negedge clk); overrun_clr = 1;
    @(negedge clk); overrun_clr = 0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
  endtask

  task automatic test_clr;
    logic [N*DW-1:0] got, e;
    int lat, bc;
    incs[0] = PW'($urandom); incs[1] = PW'($urandom);
    for (int n = 0; n < 3; n++) begin
      frame(0, got, lat, bc);
      model(e);
      checks++;
      if (got !== e) begin errors++; $display("FAIL clr_accum%0d got %h exp %h", n, got, e); end
    end
    frame(1, got, lat, bc);
    model(e);
    checks++;
    if (got !== '0 || lat !== 5) begin errors++; $display("FAIL clr_coincident got %h lat %0d exp 0 lat 5", got, lat); end
    frame(0, got, lat, bc);
    model(e);
    checks++;
    if (got !== {ref_s(incs[1], 256, 0), ref_s(incs[0], 256, 0)}) begin
      errors++; $display("FAIL clr_next got %h exp %h", got, e);
    end
  endtask

  task automatic test_async_reset;
    logic [N*DW-1:0] got, e;
    int lat, bc, n;
    incs[0] = 24'h400000; incs[1] = 24'h123456;
    pulse_clr;
    frame(0, got, lat, bc); model(e);
    frame(0, got, lat, bc); model(e);
    checks++;
    if (got !== e) begin errors++; $display("FAIL arst_pre got %h exp %h", got, e); end
    @(negedge clk); sample_req = 1;
    @(negedge clk);
    @(negedge clk); sample_req = 0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL arst_prestate got %b%b exp 11", overrun, busy); end
    #2 arst_n = 0;
    #1;
    checks++;
    if ({busy, sample_valid, overrun, sample_out} !== '0) begin
      errors++; $display("FAIL arst_immediate got %h exp 0", {busy, sample_valid, overrun, sample_out});
    end
    @(negedge clk); arst_n = 1;
    for (int k = 0; k < N; k++) mph[k] = '0;
    wait_valid(10, n, got);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL arst_no_valid got %0d exp 0", n); end
    frame(0, got, lat, bc);
    model(e);
    checks++;
    if (got !== '0 || lat !== 5) begin errors++; $display("FAIL arst_after got %h lat %0d exp 0 lat 5", got, lat); end
  endtask

  initial begin
    incs = '{0, 0};
    amps = '{256, 256};
    mph = '{0, 0};
    test_reset;
    test_quadrants;
    test_amp_fmt;
    test_wrap;
    test_random;
    test_enable;
    test_overrun;
    test_clr;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
